// File: rtl/apuf_eval_sequencer.sv
// apuf_eval_sequencer
// Runs one Arbiter PUF evaluation for the host. It latches a challenge, lets
// the delay chains settle, then fires the trigger NEVAL times. Each evaluation
// waits for the APUF ready strobe (or a timeout), and a rest gap follows every
// trigger pulse. The result is a majority-voted response bit plus the count of
// evaluations that returned 1.
//
// Handshakes:
//   host side:  start is a single-cycle request, taken only in IDLE. busy is
//               high from the accept edge until the done pulse. done is high for
//               exactly one cycle, and resp_bit/ones_cnt/timeout_err are valid
//               in that cycle and are held until the next accept.
//   APUF side:  puf_resp_ready is a strobe synchronous to clk. It is looked at
//               only while the trigger is high (TRIG), and puf_resp_bit is
//               taken on the first edge that sees it.
module apuf_eval_sequencer #(
   parameter int NCHAL       = 128,
   parameter int NEVAL       = 7,
   parameter int SETTLE_CYC  = 16,
   parameter int REST_CYC    = 8,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CW          = $clog2(NEVAL + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [NCHAL-1:0] chal_in,
   output logic             busy,
   output logic             done,
   output logic             resp_bit,
   output logic [CW-1:0]    ones_cnt,
   output logic             timeout_err,
   output logic [NCHAL-1:0] puf_chal,
   output logic             puf_tig,
   input  logic             puf_resp_ready,
   input  logic             puf_resp_bit
);

   // A majority vote needs an odd number of evaluations. Every phase must
   // also last at least one cycle.
   if (NEVAL < 1 || (NEVAL % 2) == 0) begin : gBadNeval
      $error("apuf_eval_sequencer: NEVAL must be odd and >= 1");
   end
   if (SETTLE_CYC < 1 || REST_CYC < 1 || TIMEOUT_CYC < 1) begin : gBadCycles
      $error("apuf_eval_sequencer: SETTLE_CYC, REST_CYC and TIMEOUT_CYC must be >= 1");
   end

   // One shared phase counter covers the settle, trigger-wait and rest phases.
   // It is sized for the longest of the three.
   localparam int MAXC = (SETTLE_CYC > REST_CYC)
                         ? ((SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC)
                         : ((REST_CYC > TIMEOUT_CYC) ? REST_CYC : TIMEOUT_CYC);
   localparam int TW = $clog2(MAXC + 1);

   localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] REST_LAST    = TW'(REST_CYC - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] NEVAL_C      = CW'(NEVAL);
   localparam logic [CW-1:0] HALF_C       = CW'(NEVAL / 2);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      TRIG   = 3'd2,
      REST   = 3'd3,
      DONE   = 3'd4
   } seqState_t;

   // state is a plain named register so that checkers can bind to it directly.
   seqState_t       state;
   logic [TW-1:0]   phaseCnt;
   logic [CW-1:0]   evalIdx;

   // Sequencer FSM. Every output is registered here, so puf_chal and puf_tig
   // are glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         phaseCnt    <= '0;
         evalIdx     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         resp_bit    <= 1'b0;
         ones_cnt    <= '0;
         timeout_err <= 1'b0;
         puf_chal    <= '0;
         puf_tig     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  puf_chal    <= chal_in;
                  ones_cnt    <= '0;
                  evalIdx     <= '0;
                  resp_bit    <= 1'b0;
                  timeout_err <= 1'b0;
                  busy        <= 1'b1;
                  phaseCnt    <= '0;
                  state       <= SETTLE;
               end
            end
            SETTLE: begin
               // The trigger rises on the SETTLE_CYC-th edge after accept.
               if (phaseCnt == SETTLE_LAST) begin
                  phaseCnt <= '0;
                  puf_tig  <= 1'b1;
                  state    <= TRIG;
               end else begin
                  phaseCnt <= phaseCnt + TW'(1);
               end
            end
            TRIG: begin
               // If ready and the timeout land on the same edge, the response wins.
               if (puf_resp_ready) begin
                  ones_cnt <= ones_cnt + CW'(puf_resp_bit);
                  evalIdx  <= evalIdx + CW'(1);
                  puf_tig  <= 1'b0;
                  phaseCnt <= '0;
                  state    <= REST;
               end else if (phaseCnt == TIMEOUT_LAST) begin
                  timeout_err <= 1'b1;
                  puf_tig     <= 1'b0;
                  phaseCnt    <= '0;
                  state       <= REST;
               end else begin
                  phaseCnt <= phaseCnt + TW'(1);
               end
            end
            REST: begin
               // The challenge stays put here. Only the trigger is re-armed,
               // and the delay chains are not settled again.
               if (phaseCnt == REST_LAST) begin
                  phaseCnt <= '0;
                  if (evalIdx < NEVAL_C && !timeout_err) begin
                     puf_tig <= 1'b1;
                     state   <= TRIG;
                  end else begin
                     done     <= 1'b1;
                     busy     <= 1'b0;
                     resp_bit <= (ones_cnt > HALF_C);
                     state    <= DONE;
                  end
               end else begin
                  phaseCnt <= phaseCnt + TW'(1);
               end
            end
            DONE: begin
               // done is high during this cycle. A start seen now is dropped.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
